// File: rtl/cpu_types_pkg.sv
// Shared CPU pipeline types: register numbers plus the hazard-control FSM state,
// counter type and latency bound used by hazard_ctrl_unit and hazard_match.
package cpu_types_pkg;

    localparam int REG_W = 5;
    typedef logic [REG_W-1:0] regbits_t;

    typedef enum logic {
        RUN   = 1'b0,
        STALL = 1'b1
    } hz_state_t;

    localparam int HZ_MAX_LAT = 4;
    // Wide enough for the largest bubble count: 2 + (HZ_MAX_LAT-1) without forwarding.
    localparam int HZ_CNT_W = $clog2(HZ_MAX_LAT + 2);
    typedef logic [HZ_CNT_W-1:0] hz_cnt_t;

    function automatic hz_cnt_t hz_max(input hz_cnt_t a, input hz_cnt_t b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/hazard_ctrl_unit_match.sv
// One source operand against one producer: returns the bubble count it needs.
// Bubble counts depend on the HAZ_FORWARD_EN macro (forwarding unit present).
module hazard_match
    import cpu_types_pkg::*;
#(
    parameter int LOAD_LAT = 1,
    parameter bit IS_MEM   = 1'b0
) (
    input  logic     id_valid,
    input  logic     src_use,
    input  regbits_t src,
    input  logic     p_valid,
    input  logic     p_regwrite,
    input  logic     p_memread,
    input  regbits_t p_regdst,
    output hz_cnt_t  n_bubbles
);

    logic match;

    // Register 0 is hardwired, so it never carries a dependence.
    assign match = id_valid && src_use && (src != '0) && p_valid && p_regwrite
                   && (src == p_regdst);

`ifdef HAZ_FORWARD_EN
    localparam hz_cnt_t LD_N = IS_MEM ? hz_cnt_t'(LOAD_LAT - 1) : hz_cnt_t'(LOAD_LAT);

    assign n_bubbles = (match && p_memread) ? LD_N : '0;
`else
    localparam hz_cnt_t BASE_N    = IS_MEM ? hz_cnt_t'(1) : hz_cnt_t'(2);
    localparam hz_cnt_t LAT_EXTRA = hz_cnt_t'(LOAD_LAT - 1);

    assign n_bubbles = match ? (BASE_N + (p_memread ? LAT_EXTRA : '0)) : '0;
`endif

endmodule

// File: rtl/hazard_ctrl_unit.sv
// RAW hazard detector and stall sequencer for the 5-stage pipeline, with branch
// flush, memory-wait freeze and a saturating stall counter. Optional: HAZ_FORWARD_EN.
module hazard_ctrl_unit
    import cpu_types_pkg::*;
#(
    parameter int SRC_N    = 2,
    parameter int LOAD_LAT = 1,
    parameter int PERF_W   = 32
) (
    input  logic                  CLK,
    input  logic                  nRST,
    input  logic                  id_valid,
    input  regbits_t [SRC_N-1:0]  id_src,
    input  logic [SRC_N-1:0]      id_use,
    input  logic                  ex_valid,
    input  logic                  ex_regwrite,
    input  logic                  ex_memread,
    input  regbits_t              ex_regdst,
    input  logic                  mem_valid,
    input  logic                  mem_regwrite,
    input  logic                  mem_memread,
    input  regbits_t              mem_regdst,
    input  logic                  branch_taken,
    input  logic                  mem_wait,
    output logic                  stall_pc,
    output logic                  stall_ifid,
    output logic                  bubble_idex,
    output logic                  flush_ifid,
    output logic [PERF_W-1:0]     stall_cycles,
    output hz_state_t             dbg_state,
    output hz_cnt_t               dbg_cnt
);

    localparam int CNT_W = $clog2(LOAD_LAT + 2);

    hz_state_t          state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [PERF_W-1:0]  perf_q, perf_d;
    hz_cnt_t            n_ex  [SRC_N];
    hz_cnt_t            n_mem [SRC_N];
    hz_cnt_t            n_max;
    logic               pc_c, ifid_c, bub_c, flush_c;

    generate
        for (genvar i = 0; i < SRC_N; i++) begin : g_src
            hazard_match #(.LOAD_LAT(LOAD_LAT), .IS_MEM(1'b0)) u_ex (
                .id_valid   (id_valid),
                .src_use    (id_use[i]),
                .src        (id_src[i]),
                .p_valid    (ex_valid),
                .p_regwrite (ex_regwrite),
                .p_memread  (ex_memread),
                .p_regdst   (ex_regdst),
                .n_bubbles  (n_ex[i])
            );
            hazard_match #(.LOAD_LAT(LOAD_LAT), .IS_MEM(1'b1)) u_mem (
                .id_valid   (id_valid),
                .src_use    (id_use[i]),
                .src        (id_src[i]),
                .p_valid    (mem_valid),
                .p_regwrite (mem_regwrite),
                .p_memread  (mem_memread),
                .p_regdst   (mem_regdst),
                .n_bubbles  (n_mem[i])
            );
        end
    endgenerate

    always_comb begin
        n_max = '0;
        for (int i = 0; i < SRC_N; i++) begin
            n_max = hz_max(n_max, n_ex[i]);
            n_max = hz_max(n_max, n_mem[i]);
        end
    end

    // Priority: memory freeze, then branch squash, then an in-flight stall, then detection.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pc_c    = 1'b0;
        ifid_c  = 1'b0;
        bub_c   = 1'b0;
        flush_c = 1'b0;
        if (mem_wait) begin
            pc_c   = 1'b1;
            ifid_c = 1'b1;
        end else if (branch_taken) begin
            flush_c = 1'b1;
            bub_c   = 1'b1;
            state_d = RUN;
            cnt_d   = '0;
        end else if (state_q == STALL) begin
            pc_c   = 1'b1;
            ifid_c = 1'b1;
            bub_c  = 1'b1;
            if (cnt_q == CNT_W'(1)) begin
                state_d = RUN;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q - CNT_W'(1);
            end
        end else if (n_max != '0) begin
            pc_c   = 1'b1;
            ifid_c = 1'b1;
            bub_c  = 1'b1;
            if (n_max >= hz_cnt_t'(2)) begin
                state_d = STALL;
                cnt_d   = CNT_W'(n_max - hz_cnt_t'(1));
            end
        end
    end

    always_comb begin
        perf_d = perf_q;
        if (bub_c && !flush_c && (perf_q != '1)) begin
            perf_d = perf_q + PERF_W'(1);
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= RUN;
            cnt_q   <= '0;
            perf_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            perf_q  <= perf_d;
        end
    end

    // Mealy outputs are forced low for the whole time reset is asserted.
    assign stall_pc     = pc_c & nRST;
    assign stall_ifid   = ifid_c & nRST;
    assign bubble_idex  = bub_c & nRST;
    assign flush_ifid   = flush_c & nRST;
    assign stall_cycles = perf_q;
    assign dbg_state    = state_q;
    assign dbg_cnt      = hz_cnt_t'(cnt_q);

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Directed bench for hazard_ctrl_unit: instance A (LOAD_LAT=3, PERF_W=4) and
// instance B (LOAD_LAT=1, PERF_W=32) share one stimulus stream.
module tb_hazard_ctrl_unit;
    import cpu_types_pkg::*;

`ifdef HAZ_FORWARD_EN
    localparam int EX_ALU = 0, MEM_ALU = 0;
    localparam int A_EX_LD = 3, A_MEM_LD = 2, A_MAX = 2;
    localparam int B_EX_LD = 1, B_MEM_LD = 0, B_MAX = 0;
`else
    localparam int EX_ALU = 2, MEM_ALU = 1;
    localparam int A_EX_LD = 4, A_MEM_LD = 3, A_MAX = 3;
    localparam int B_EX_LD = 2, B_MEM_LD = 1, B_MAX = 2;
`endif

    logic                 CLK = 1'b0;
    logic                 nRST;
    logic                 id_valid;
    regbits_t [1:0]       id_src;
    logic [1:0]           id_use;
    logic                 ex_valid, ex_regwrite, ex_memread;
    regbits_t             ex_regdst;
    logic                 mem_valid, mem_regwrite, mem_memread;
    regbits_t             mem_regdst;
    logic                 branch_taken, mem_wait;

    logic                 a_pc, a_ifid, a_bub, a_flush;
    logic [3:0]           a_perf;
    hz_state_t            a_state;
    hz_cnt_t              a_cnt;
    logic                 b_pc, b_ifid, b_bub, b_flush;
    logic [31:0]          b_perf;
    hz_state_t            b_state;
    hz_cnt_t              b_cnt;
    logic [3:0]           a_ctl, b_ctl;

    int total = 0;
    int bad = 0;
    int exp_perf_a = 0;
    int exp_perf_b = 0;

    assign a_ctl = {a_pc, a_ifid, a_bub, a_flush};
    assign b_ctl = {b_pc, b_ifid, b_bub, b_flush};

    always #5 CLK = ~CLK;

    hazard_ctrl_unit #(.SRC_N(2), .LOAD_LAT(3), .PERF_W(4)) dut_a (
        .CLK(CLK), .nRST(nRST), .id_valid(id_valid), .id_src(id_src), .id_use(id_use),
        .ex_valid(ex_valid), .ex_regwrite(ex_regwrite), .ex_memread(ex_memread), .ex_regdst(ex_regdst),
        .mem_valid(mem_valid), .mem_regwrite(mem_regwrite), .mem_memread(mem_memread), .mem_regdst(mem_regdst),
        .branch_taken(branch_taken), .mem_wait(mem_wait),
        .stall_pc(a_pc), .stall_ifid(a_ifid), .bubble_idex(a_bub), .flush_ifid(a_flush),
        .stall_cycles(a_perf), .dbg_state(a_state), .dbg_cnt(a_cnt)
    );

    hazard_ctrl_unit #(.SRC_N(2), .LOAD_LAT(1), .PERF_W(32)) dut_b (
        .CLK(CLK), .nRST(nRST), .id_valid(id_valid), .id_src(id_src), .id_use(id_use),
        .ex_valid(ex_valid), .ex_regwrite(ex_regwrite), .ex_memread(ex_memread), .ex_regdst(ex_regdst),
        .mem_valid(mem_valid), .mem_regwrite(mem_regwrite), .mem_memread(mem_memread), .mem_regdst(mem_regdst),
        .branch_taken(branch_taken), .mem_wait(mem_wait),
        .stall_pc(b_pc), .stall_ifid(b_ifid), .bubble_idex(b_bub), .flush_ifid(b_flush),
        .stall_cycles(b_perf), .dbg_state(b_state), .dbg_cnt(b_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic set_ex(input logic v, input logic rw, input logic mr, input int dst);
        ex_valid = v; ex_regwrite = rw; ex_memread = mr; ex_regdst = regbits_t'(dst);
    endtask

    task automatic set_mem(input logic v, input logic rw, input logic mr, input int dst);
        mem_valid = v; mem_regwrite = rw; mem_memread = mr; mem_regdst = regbits_t'(dst);
    endtask

    task automatic set_id(input logic v, input logic [1:0] use_m, input int s0, input int s1);
        id_valid = v; id_use = use_m; id_src[0] = regbits_t'(s0); id_src[1] = regbits_t'(s1);
    endtask

    task automatic clear_prod();
        set_ex(1'b0, 1'b0, 1'b0, 0);
        set_mem(1'b0, 1'b0, 1'b0, 0);
    endtask

    // Entered just after a rising edge with the hazard applied; the producers
    // retire after the detection cycle, as they would in the pipeline.
    task automatic expect_seq(input string tag, input int na, input int nb);
        int last;
        last = (na > nb) ? na : nb;
        for (int k = 0; k <= last; k++) begin
            @(negedge CLK);
            chk({tag, "_a_ctl"}, a_ctl, (k < na) ? 4'b1110 : 4'b0000);
            chk({tag, "_b_ctl"}, b_ctl, (k < nb) ? 4'b1110 : 4'b0000);
            chk({tag, "_a_state"}, a_state, (k >= 1 && k < na) ? STALL : RUN);
            chk({tag, "_a_cnt"}, a_cnt, (k >= 1 && k < na) ? na - k : 0);
            @(posedge CLK);
            #1;
            if (k == 0) clear_prod();
        end
        exp_perf_a = (exp_perf_a + na > 15) ? 15 : exp_perf_a + na;
        exp_perf_b = exp_perf_b + nb;
        chk({tag, "_a_perf"}, a_perf, exp_perf_a);
        chk({tag, "_b_perf"}, b_perf, exp_perf_b);
    endtask

    task automatic do_reset();
        clear_prod();
        branch_taken = 1'b0;
        mem_wait = 1'b0;
        nRST = 1'b0;
        #1;
        chk("rst_a_perf", a_perf, 0);
        chk("rst_a_ctl", a_ctl, 0);
        @(negedge CLK);
        nRST = 1'b1;
        @(posedge CLK);
        #1;
    endtask

    // Drives instance A from a fresh EX load into STALL with cnt=2.
    task automatic reach_stall2();
        set_ex(1'b1, 1'b1, 1'b1, 6);
        set_id(1'b1, 2'b11, 6, 0);
        @(posedge CLK);
        #1;
        clear_prod();
        repeat (A_EX_LD - 3) begin
            @(posedge CLK);
            #1;
        end
        chk("s2_state", a_state, STALL);
        chk("s2_cnt", a_cnt, 2);
    endtask

    initial begin
        nRST = 1'b0;
        branch_taken = 1'b0;
        mem_wait = 1'b0;
        set_mem(1'b0, 1'b0, 1'b0, 0);
        set_ex(1'b1, 1'b1, 1'b1, 2);
        set_id(1'b1, 2'b11, 2, 9);
        #2;
        chk("init_a_ctl", a_ctl, 0);
        chk("init_b_ctl", b_ctl, 0);
        chk("init_a_perf", a_perf, 0);
        chk("init_b_perf", b_perf, 0);
        chk("init_a_state", a_state, RUN);
        chk("init_a_cnt", a_cnt, 0);
        clear_prod();
        @(negedge CLK);
        nRST = 1'b1;
        @(posedge CLK);
        #1;

        set_ex(1'b1, 1'b1, 1'b1, 2); set_id(1'b1, 2'b11, 2, 9);
        expect_seq("ex_ld", A_EX_LD, B_EX_LD);
        set_ex(1'b1, 1'b1, 1'b1, 0); set_id(1'b1, 2'b11, 0, 9);
        expect_seq("reg0", 0, 0);
        set_ex(1'b1, 1'b1, 1'b0, 7); set_id(1'b1, 2'b11, 7, 1);
        expect_seq("ex_alu", EX_ALU, EX_ALU);
        set_mem(1'b1, 1'b1, 1'b0, 7); set_id(1'b1, 2'b11, 3, 7);
        expect_seq("mem_alu", MEM_ALU, MEM_ALU);
        set_ex(1'b1, 1'b1, 1'b0, 7); set_id(1'b1, 2'b10, 7, 1);
        expect_seq("no_use", 0, 0);
        set_mem(1'b1, 1'b1, 1'b1, 4); set_id(1'b1, 2'b11, 1, 4);
        expect_seq("mem_ld", A_MEM_LD, B_MEM_LD);
        set_ex(1'b1, 1'b1, 1'b0, 3); set_mem(1'b1, 1'b1, 1'b1, 4); set_id(1'b1, 2'b11, 3, 4);
        expect_seq("max", A_MAX, B_MAX);
        set_ex(1'b1, 1'b1, 1'b1, 5); set_id(1'b0, 2'b11, 5, 5);
        expect_seq("id_inv", 0, 0);
        set_ex(1'b1, 1'b0, 1'b1, 5); set_id(1'b1, 2'b11, 5, 5);
        expect_seq("no_rw", 0, 0);

        // Branch taken while stalling: squash, no count, back to RUN.
        do_reset();
        reach_stall2();
        branch_taken = 1'b1;
        @(negedge CLK);
        chk("br_ctl", a_ctl, 4'b0011);
        chk("br_perf_before", a_perf, A_EX_LD - 2);
        @(posedge CLK);
        #1;
        branch_taken = 1'b0;
        chk("br_state", a_state, RUN);
        chk("br_cnt", a_cnt, 0);
        chk("br_perf_after", a_perf, A_EX_LD - 2);
        @(negedge CLK);
        chk("br_idle_ctl", a_ctl, 0);
        @(posedge CLK);
        #1;

        // Asynchronous reset in the middle of a stall.
        reach_stall2();
        #2;
        nRST = 1'b0;
        #1;
        chk("mid_rst_a_ctl", a_ctl, 0);
        chk("mid_rst_b_ctl", b_ctl, 0);
        chk("mid_rst_perf", a_perf, 0);
        chk("mid_rst_state", a_state, RUN);
        chk("mid_rst_cnt", a_cnt, 0);
        @(negedge CLK);
        nRST = 1'b1;
        @(posedge CLK);
        #1;

        // Memory wait freezes the stall sequence.
        reach_stall2();
        mem_wait = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            chk("mw_ctl", a_ctl, 4'b1100);
            @(posedge CLK);
            #1;
            chk("mw_state", a_state, STALL);
            chk("mw_cnt", a_cnt, 2);
        end
        chk("mw_perf", a_perf, A_EX_LD - 2);
        mem_wait = 1'b0;
        @(negedge CLK);
        chk("mw_rel1_ctl", a_ctl, 4'b1110);
        @(posedge CLK);
        #1;
        chk("mw_rel1_cnt", a_cnt, 1);
        @(negedge CLK);
        chk("mw_rel2_ctl", a_ctl, 4'b1110);
        @(posedge CLK);
        #1;
        chk("mw_rel2_state", a_state, RUN);
        chk("mw_rel2_cnt", a_cnt, 0);
        @(negedge CLK);
        chk("mw_done_ctl", a_ctl, 0);
        chk("mw_done_perf", a_perf, A_EX_LD);
        @(posedge CLK);
        #1;

        // Continuous load dependence: every cycle stalls, A saturates at 15.
        do_reset();
        set_ex(1'b1, 1'b1, 1'b1, 2);
        set_id(1'b1, 2'b11, 2, 0);
        repeat (15) begin
            @(posedge CLK);
            #1;
        end
        chk("sat15_a_perf", a_perf, 15);
        repeat (5) begin
            @(posedge CLK);
            #1;
        end
        chk("sat20_a_perf", a_perf, 15);
        chk("sat20_b_perf", b_perf, 20);
        chk("sat20_a_ctl", a_ctl, 4'b1110);
        clear_prod();
        repeat (6) begin
            @(posedge CLK);
            #1;
        end
        chk("end_a_ctl", a_ctl, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl_unit.md
Name: hazard_ctrl_unit

Overview:
- Parametrised successor to the pipeline hazard detector.
- Detects RAW hazards between the instruction in ID and the producers in EX and MEM, for a configurable number of source operands and a configurable load latency.
- Issues a multi-cycle stall sequence through a counter/FSM, and also handles taken-branch flush, memory-wait freeze and a stall performance counter.
- Sits between the IF/ID, ID/EX and PC-enable logic of the 5-stage pipeline.

Parameters:
- SRC_N, 2, number of ID source operands checked (1..3).
- LOAD_LAT, 1, cycles before load data can be forwarded after the load leaves EX (1..4).
- PERF_W, 32, stall-cycle counter width.

Ports:
- CLK  in  1  clock, rising edge.
- nRST  in  1  reset, asynchronous, active-low.
- id_valid  in  1  ID holds a real instruction.
- id_src  in  SRC_N x regbits_t  ID source register numbers.
- id_use  in  SRC_N  per-source "operand actually read".
- ex_valid, ex_regwrite, ex_memread  in  1 each  EX producer qualifiers.
- ex_regdst  in  regbits_t  EX destination register.
- mem_valid, mem_regwrite, mem_memread  in  1 each  MEM producer qualifiers.
- mem_regdst  in  regbits_t  MEM destination register.
- branch_taken  in  1  EX resolved a taken branch or jump.
- mem_wait  in  1  data memory not ready; freeze the pipeline.
- stall_pc  out  1  hold the PC.
- stall_ifid  out  1  hold IF/ID.
- bubble_idex  out  1  load a NOP into ID/EX.
- flush_ifid  out  1  squash IF/ID.
- stall_cycles  out  PERF_W  saturating count of hazard-stall cycles.

Behaviour:
- Reset (asynchronous, nRST low):
  - state RUN, cnt 0, stall_cycles 0.
  - All control outputs 0 while nRST is low.
- Match for source i against producer P:
  - id_valid & id_use[i] & id_src[i] != 0 & P_valid & P_regwrite & id_src[i] == P_regdst.
  - Register 0 never matches.
- Required bubbles N for a match (see Optional Feature), computed per (i, P); N = max over all i and P.
- Outputs are combinational from state and inputs (Mealy). A stall begins in the detection cycle.
- Priority, highest first: mem_wait > branch_taken > STALL counting > new detection.
- mem_wait=1:
  - stall_pc = stall_ifid = 1; bubble_idex = 0; flush_ifid = 0.
  - state, cnt and stall_cycles hold.
  - No detection that cycle.
- branch_taken=1 (and mem_wait=0):
  - flush_ifid = 1, bubble_idex = 1, stalls = 0.
  - state <= RUN, cnt <= 0. Any pending stall is abandoned because the dependent instruction is squashed.
- State RUN:
  - N=0: all outputs 0.
  - N>=1: stall_pc = stall_ifid = bubble_idex = 1.
  - N=1: stay in RUN.
  - N>=2: go to STALL with cnt <= N-1.
- State STALL:
  - stall_pc = stall_ifid = bubble_idex = 1. Detection is ignored.
  - cnt==1: go to RUN, cnt <= 0.
  - Otherwise cnt <= cnt-1.
- stall_cycles increments by 1 in every cycle with bubble_idex=1 and flush_ifid=0. It saturates at all-ones.
- cnt width is clog2(LOAD_LAT+2).

Optional Feature:
- Macro HAZ_FORWARD_EN.
- Defined (forwarding unit present): only loads stall.
  - EX load match: N = LOAD_LAT.
  - MEM load match: N = LOAD_LAT-1.
  - Non-load match: N = 0.
- Undefined (no forwarding; register file is write-before-read):
  - EX match: N = 2 + (ex_memread ? LOAD_LAT-1 : 0).
  - MEM match: N = 1 + (mem_memread ? LOAD_LAT-1 : 0).

Decomposition:
- cpu_types_pkg gains:
  - hz_state_t enum {RUN, STALL}.
  - HZ_MAX_LAT = 4.
  - hz_cnt_t.
- Existing regbits_t is reused.
- Sub-module hazard_match: combinational; takes one source plus one producer and returns N. Instantiated SRC_N x 2 times in a generate loop. The max reduction and FSM stay in the top module.

Test Plan:
- Forwarding on, LOAD_LAT=1: lw $2 in EX, ID add reads $2 -> one cycle of stall_pc/stall_ifid/bubble_idex, state stays RUN, stall_cycles = 1.
- Forwarding on, LOAD_LAT=3: lw $5 in EX, ID rt=$5 -> 3 stall cycles (RUN->STALL with cnt=2, then 1, then RUN); $0 dependence -> no stall.
- Forwarding off: add $7 in EX, ID rs=$7 -> 2 stalls; add $7 in MEM only -> 1 stall; id_use[rs]=0 -> no stall.
- STALL with cnt=2 plus branch_taken=1 -> flush_ifid=1, bubble_idex=1, stalls 0, state RUN next cycle, counter not incremented that cycle.
- STALL with cnt=2 plus mem_wait=1 for 3 cycles -> bubble_idex=0, cnt holds at 2; after release, 2 more stall cycles.
- PERF_W=4: force 20 stall cycles -> stall_cycles saturates at 15; nRST pulse mid-STALL -> outputs 0 immediately, counter 0.
